// File: rtl/rgbc_pkg.sv
// Shared types and the dominant-colour decision for the RGBC colour classifier.
package rgbc_pkg;

    typedef enum logic [1:0] {COL_UNKNOWN, COL_RED, COL_GREEN, COL_BLUE} color_t;

    typedef enum logic [2:0] {ACCUM, AVG, DIV_R, DIV_G, DIV_B, CLASSIFY} cls_state_t;

    localparam logic [7:0]  Q8_MAX     = 8'd255;
    localparam int unsigned DVD_W      = 24;
    localparam int unsigned DVS_W      = 16;
    localparam int unsigned DIV_ITERS  = 24;
    localparam int unsigned DIV_CNT_W  = 5;

    // A channel wins only if it clears the floor and beats both others by the margin (9-bit sums).
    function automatic color_t classify(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b, input logic [7:0] dom,
                                        input logic [7:0] margin);
        logic [8:0] r9, g9, b9, rm, gm, bm;
        logic       r_ok, g_ok, b_ok;
        color_t     res;
        r9 = {1'b0, r};
        g9 = {1'b0, g};
        b9 = {1'b0, b};
        rm = r9 + {1'b0, margin};
        gm = g9 + {1'b0, margin};
        bm = b9 + {1'b0, margin};
        r_ok = (r >= dom) && (r9 >= gm) && (r9 >= bm);
        g_ok = (g >= dom) && (g9 >= rm) && (g9 >= bm);
        b_ok = (b >= dom) && (b9 >= rm) && (b9 >= gm);
        case ({r_ok, g_ok, b_ok})
            3'b100:  res = COL_RED;
            3'b010:  res = COL_GREEN;
            3'b001:  res = COL_BLUE;
            default: res = COL_UNKNOWN;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rgbc_divider.sv
// Restoring 24/16 divider: one load cycle, 24 iteration cycles, result saturated to 8 bits.
module rgbc_divider
    import rgbc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [7:0]       q_c
);

    logic [DVS_W-1:0]     rem;
    logic [DVD_W-1:0]     quo;
    logic [DVS_W-1:0]     dvs;
    logic [DIV_CNT_W-1:0] cnt;
    logic                 busy;
    logic [DVS_W:0]       trial_c;
    logic                 ge_c;

    always_comb begin
        trial_c = {rem, quo[DVD_W-1]};
        ge_c    = trial_c >= {1'b0, dvs};
        q_c     = (|quo[DVD_W-1:8]) ? Q8_MAX : quo[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            // Remainder stays below the divisor, so it always fits back into DVS_W bits.
            rem <= ge_c ? DVS_W'(trial_c - {1'b0, dvs}) : trial_c[DVS_W-1:0];
            quo <= {quo[DVD_W-2:0], ge_c};
            cnt <= cnt + DIV_CNT_W'(1);
            if (cnt == DIV_CNT_W'(DIV_ITERS - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgbc_color_classifier.sv
// Averages RGBC samples, normalises each channel to clear, classifies and debounces the colour.
module rgbc_color_classifier
    import rgbc_pkg::*;
#(
    parameter int unsigned AVG_LOG2     = 2,
    parameter logic [15:0] MIN_CLEAR    = 16'd64,
    parameter logic [7:0]  DOM_Q8       = 8'd102,
    parameter logic [7:0]  MARGIN_Q8    = 8'd16,
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] clear,
    input  logic [15:0] red,
    input  logic [15:0] green,
    input  logic [15:0] blue,
    input  logic        data_valid,
    output logic        is_red,
    output logic        is_green,
    output logic        is_blue,
    output logic        is_unknown,
    output logic [7:0]  r_q8,
    output logic [7:0]  g_q8,
    output logic [7:0]  b_q8,
    output logic        class_valid,
    output logic        overrun
);

    localparam int unsigned ACC_W   = 16 + AVG_LOG2;
    localparam int unsigned SCNT_W  = AVG_LOG2 + 1;
    localparam int unsigned NSAMP   = 1 << AVG_LOG2;
    localparam int unsigned STAB_W  = 4;

    cls_state_t           state;
    logic [ACC_W-1:0]     acc_c, acc_r, acc_g, acc_b;
    logic [SCNT_W-1:0]    samp_cnt;
    logic [15:0]          avg_clr, avg_r, avg_g, avg_b;
    logic                 low_clear;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic [7:0]           ratio_r, ratio_g;
    color_t               last_cand;
    logic [STAB_W-1:0]    stable_cnt;

    logic [15:0]          avg_clr_c;
    logic [15:0]          div_chan_c;
    logic                 div_start_c;
    logic                 div_done;
    logic [7:0]           div_q;
    color_t               cand_c;
    logic [STAB_W-1:0]    stable_next_c;

    always_comb begin
        avg_clr_c   = 16'(acc_c >> AVG_LOG2);
        div_chan_c  = avg_r;
        div_start_c = 1'b0;
        case (state)
            DIV_R: div_start_c = (div_cnt == '0);
            DIV_G: begin
                div_chan_c  = avg_g;
                div_start_c = (div_cnt == '0);
            end
            DIV_B: begin
                div_chan_c  = avg_b;
                div_start_c = (div_cnt == '0);
            end
            default: ;
        endcase
        cand_c = low_clear ? COL_UNKNOWN : classify(ratio_r, ratio_g, div_q, DOM_Q8, MARGIN_Q8);
        if (cand_c == last_cand)
            stable_next_c = (stable_cnt >= STAB_W'(STABLE_COUNT)) ? stable_cnt
                                                                  : stable_cnt + STAB_W'(1);
        else
            stable_next_c = STAB_W'(1);
    end

    rgbc_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend ({div_chan_c, 8'h00}),
        .divisor  (avg_clr),
        .done     (div_done),
        .q_c      (div_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACCUM;
            acc_c       <= '0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            samp_cnt    <= '0;
            avg_clr     <= '0;
            avg_r       <= '0;
            avg_g       <= '0;
            avg_b       <= '0;
            low_clear   <= 1'b0;
            div_cnt     <= '0;
            ratio_r     <= '0;
            ratio_g     <= '0;
            last_cand   <= COL_UNKNOWN;
            stable_cnt  <= '0;
            is_red      <= 1'b0;
            is_green    <= 1'b0;
            is_blue     <= 1'b0;
            is_unknown  <= 1'b1;
            r_q8        <= '0;
            g_q8        <= '0;
            b_q8        <= '0;
            class_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (data_valid && (state != ACCUM))
                overrun <= 1'b1;
            case (state)
                ACCUM: if (data_valid) begin
                    acc_c    <= acc_c + ACC_W'(clear);
                    acc_r    <= acc_r + ACC_W'(red);
                    acc_g    <= acc_g + ACC_W'(green);
                    acc_b    <= acc_b + ACC_W'(blue);
                    samp_cnt <= samp_cnt + SCNT_W'(1);
                    if (samp_cnt == SCNT_W'(NSAMP - 1))
                        state <= AVG;
                end
                AVG: begin
                    avg_clr   <= avg_clr_c;
                    avg_r     <= 16'(acc_r >> AVG_LOG2);
                    avg_g     <= 16'(acc_g >> AVG_LOG2);
                    avg_b     <= 16'(acc_b >> AVG_LOG2);
                    acc_c     <= '0;
                    acc_r     <= '0;
                    acc_g     <= '0;
                    acc_b     <= '0;
                    samp_cnt  <= '0;
                    div_cnt   <= '0;
                    low_clear <= avg_clr_c < MIN_CLEAR;
                    state     <= (avg_clr_c < MIN_CLEAR) ? CLASSIFY : DIV_R;
                end
                DIV_R, DIV_G, DIV_B: begin
                    // Each later divide's load cycle banks the previous channel's quotient.
                    if (div_cnt == '0 && div_done) begin
                        if (state == DIV_G) ratio_r <= div_q;
                        if (state == DIV_B) ratio_g <= div_q;
                    end
                    if (div_cnt == DIV_CNT_W'(DIV_ITERS)) begin
                        div_cnt <= '0;
                        case (state)
                            DIV_R:   state <= DIV_G;
                            DIV_G:   state <= DIV_B;
                            default: state <= CLASSIFY;
                        endcase
                    end else begin
                        div_cnt <= div_cnt + DIV_CNT_W'(1);
                    end
                end
                CLASSIFY: begin
                    class_valid <= 1'b1;
                    last_cand   <= cand_c;
                    stable_cnt  <= stable_next_c;
                    if (stable_next_c == STAB_W'(STABLE_COUNT)) begin
                        is_red     <= (cand_c == COL_RED);
                        is_green   <= (cand_c == COL_GREEN);
                        is_blue    <= (cand_c == COL_BLUE);
                        is_unknown <= (cand_c == COL_UNKNOWN);
                    end
                    if (!low_clear) begin
                        r_q8 <= ratio_r;
                        g_q8 <= ratio_g;
                        b_q8 <= div_q;
                    end
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_rgbc_color_classifier.sv
// Directed scoreboard bench for rgbc_color_classifier with single-sample averaging.
module tb_rgbc_color_classifier;

    localparam int STABLE   = 3;
    localparam int DOM      = 102;
    localparam int MARGIN   = 16;
    localparam int MINCLR   = 64;
    localparam int LAT_FULL = 77;   // class_valid set by edge t+77, seen during cycle t+78
    localparam int LAT_LOW  = 2;    // low-clear path: CLASSIFY edge is t+2

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clear, red, green, blue;
    logic        data_valid;
    logic        is_red, is_green, is_blue, is_unknown;
    logic [7:0]  r_q8, g_q8, b_q8;
    logic        class_valid, overrun;

    rgbc_color_classifier #(
        .AVG_LOG2     (0),
        .MIN_CLEAR    (16'd64),
        .DOM_Q8       (8'd102),
        .MARGIN_Q8    (8'd16),
        .STABLE_COUNT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .data_valid  (data_valid),
        .is_red      (is_red),
        .is_green    (is_green),
        .is_blue     (is_blue),
        .is_unknown  (is_unknown),
        .r_q8        (r_q8),
        .g_q8        (g_q8),
        .b_q8        (b_q8),
        .class_valid (class_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r, g, b;
        logic [3:0] fl_before, fl_after;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int t_edge = 0;

    int         m_last = 0, m_cnt = 0, m_col = 0;
    logic [7:0] m_r = '0, m_g = '0, m_b = '0;

    function automatic logic [3:0] col_flags(input int c);
        case (c)
            1:       return 4'b1000;
            2:       return 4'b0100;
            3:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [7:0] ratio_of(input int ch, input int cl);
        int q;
        q = (ch * 256) / cl;
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    function automatic int pick(input int r, input int g, input int b);
        int v[3];
        int winner, n;
        bit ok;
        v = '{r, g, b};
        winner = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            ok = (v[i] >= DOM);
            for (int j = 0; j < 3; j++)
                if (j != i && v[i] < v[j] + MARGIN) ok = 0;
            if (ok) begin
                n++;
                winner = i + 1;
            end
        end
        return (n == 1) ? winner : 0;
    endfunction

    function automatic logic [3:0] flags_now();
        return {is_red, is_green, is_blue, is_unknown};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 0;
        m_cnt  = 0;
        m_col  = 0;
        m_r    = '0;
        m_g    = '0;
        m_b    = '0;
    endtask

    // Push the expected outcome, then present one sample for a single cycle.
    task automatic send(input int cl, input int r, input int g, input int b);
        exp_t e;
        int   cand;
        e.fl_before = col_flags(m_col);
        if (cl < MINCLR) begin
            cand  = 0;
            e.lat = LAT_LOW;
        end else begin
            m_r   = ratio_of(r, cl);
            m_g   = ratio_of(g, cl);
            m_b   = ratio_of(b, cl);
            cand  = pick(int'(m_r), int'(m_g), int'(m_b));
            e.lat = LAT_FULL;
        end
        if (cand == m_last) begin
            if (m_cnt < STABLE) m_cnt++;
        end else begin
            m_last = cand;
            m_cnt  = 1;
        end
        if (m_cnt == STABLE) m_col = cand;
        e.r = m_r;
        e.g = m_g;
        e.b = m_b;
        e.fl_after = col_flags(m_col);
        sb.push_back(e);

        @(negedge clk);
        clear      = 16'(cl);
        red        = 16'(r);
        green      = 16'(g);
        blue       = 16'(b);
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        t_edge     = cyc;
        data_valid = 1'b0;
        check("cv_low_at_accept", 32'(class_valid), 32'd0);
    endtask

    // Wait (bounded) for the next class_valid and compare it against the scoreboard head.
    task automatic wait_class(input string tag);
        exp_t       e;
        logic [3:0] fl_prev;
        int         lat;
        bit         seen;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e       = sb.pop_front();
        fl_prev = flags_now();
        seen    = 0;
        lat     = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (class_valid) begin
                seen = 1;
                lat  = cyc - t_edge;
            end else begin
                fl_prev = flags_now();
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_flags_hold"}, 32'(fl_prev), 32'(e.fl_before));
        check({tag, "_flags"}, 32'(flags_now()), 32'(e.fl_after));
        check({tag, "_r_q8"}, 32'(r_q8), 32'(e.r));
        check({tag, "_g_q8"}, 32'(g_q8), 32'(e.g));
        check({tag, "_b_q8"}, 32'(b_q8), 32'(e.b));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, 32'(flags_now()), 32'(4'b0001));
        check({tag, "_r_q8"}, 32'(r_q8), 32'd0);
        check({tag, "_g_q8"}, 32'(g_q8), 32'd0);
        check({tag, "_b_q8"}, 32'(b_q8), 32'd0);
        check({tag, "_class_valid"}, 32'(class_valid), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        clear      = '0;
        red        = '0;
        green      = '0;
        blue       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin send(1000, 600, 200, 150); wait_class("red");    end
        for (int k = 0; k < 3; k++) begin send(40, 500, 10, 10);     wait_class("lowclr"); end
        for (int k = 0; k < 3; k++) begin send(1000, 2000, 100, 100); wait_class("sat");   end
        for (int k = 0; k < 3; k++) begin send(1000, 100, 600, 100); wait_class("green");  end
        for (int k = 0; k < 3; k++) begin send(1000, 400, 400, 50);  wait_class("tie");    end

        // Sample strobed during DIV_G must be dropped and flagged.
        check("overrun_before", 32'(overrun), 32'd0);
        send(1000, 600, 200, 150);
        repeat (34) @(posedge clk);
        @(negedge clk);
        clear      = 16'd1000;
        red        = 16'd10;
        green      = 16'd10;
        blue       = 16'd900;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_class("ovr");
        send(1000, 600, 200, 150);
        wait_class("after_ovr");
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset in the middle of the blue divide.
        send(1000, 100, 600, 100);
        repeat (59) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin send(1000, 600, 200, 150); wait_class("post_rst"); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
